// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scheduler.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ACTIVE = 2'd2
  } sched_state_e;

  localparam logic [23:0] BG_WHITE  = 24'hFFFFFF;
  localparam int          SPR_CELLS = 16;

endpackage

// File: rtl/sprite_box_hit.sv
// Combinational box test for one sprite: x0 < x <= x0+box, y0 < y <= y0+box.
// Coordinates are widened by one bit so the far edge never wraps.
module sprite_box_hit
  import sprite_pkg::*;
#(
  parameter int SCALE = 8
) (
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic [9:0] i_x0,
  input  logic [8:0] i_y0,
  output logic       o_hit
);

  localparam int BOX = SPR_CELLS * SCALE;

  logic [10:0] w_x, w_x0, w_x1;
  logic [9:0]  w_y, w_y0, w_y1;

  // Extend and compare against both box edges
  always_comb begin
    w_x   = {1'b0, i_x};
    w_x0  = {1'b0, i_x0};
    w_x1  = w_x0 + 11'(BOX);
    w_y   = {1'b0, i_y};
    w_y0  = {1'b0, i_y0};
    w_y1  = w_y0 + 10'(BOX);
    o_hit = (w_x > w_x0) && (w_x <= w_x1) && (w_y > w_y0) && (w_y <= w_y1);
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame round-robin sprite arbitration plus priority pixel compositor.
// Optional macro SPRITE_SCHED_HOLD_EN: sprites shown last frame that still
// request are re-granted first; remaining slots filled round-robin.
//
// state  | meaning
// IDLE   | after reset, nothing granted yet
// ARB    | scanning one sprite index per cycle, busy high
// ACTIVE | grants frozen for the frame, compositing
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int NSPR    = 4,
  parameter int MAX_ACT = 2,
  parameter int SCALE   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic                 frame_start,
  input  logic [NSPR-1:0]      req,
  input  logic [NSPR*10-1:0]   req_x0,
  input  logic [NSPR*9-1:0]    req_y0,
  input  logic [NSPR*24-1:0]   spr_rgb,
  output logic [NSPR-1:0]      chosen,
  output logic [NSPR*10-1:0]   x0_out,
  output logic [NSPR*9-1:0]    y0_out,
  output logic [7:0]           r,
  output logic [7:0]           g,
  output logic [7:0]           b,
  output logic                 busy
);

  localparam int              PW        = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam logic [PW:0]     NSPR_W    = (PW+1)'(NSPR);
  localparam logic [PW:0]     MAX_W     = (PW+1)'(MAX_ACT);
  localparam logic [PW-1:0]   SCAN_LAST = PW'(NSPR-1);

  sched_state_e        r_state, w_state_nxt;
  logic [PW-1:0]       r_scan, r_rr_ptr, r_last_idx;
  logic [PW-1:0]       w_idx, w_last_nxt, w_rr_nxt;
  logic [PW:0]         r_cnt, w_sum, w_pre_cnt;
  logic                r_any, w_any_nxt;
  logic [NSPR-1:0]     r_grant, r_chosen, w_pre, w_grant_nxt, w_hit;
  logic [NSPR*10-1:0]  r_x0;
  logic [NSPR*9-1:0]   r_y0;
  logic                w_enter_arb, w_scan_grant, w_scan_done, w_busy;
  logic [9:0]          r_x_d;
  logic [8:0]          r_y_d;
  logic [23:0]         w_pix, r_pix;

  // Scan index = (rr_ptr + scan) mod NSPR
  always_comb begin
    w_sum = {1'b0, r_rr_ptr} + {1'b0, r_scan};
    if (w_sum >= NSPR_W) w_idx = PW'(w_sum - NSPR_W);
    else                 w_idx = w_sum[PW-1:0];
  end

`ifdef SPRITE_SCHED_HOLD_EN
  // Sprites still requesting keep their slot from the previous frame
  always_comb begin
    w_pre     = r_chosen & req;
    w_pre_cnt = '0;
    for (int i = 0; i < NSPR; i++) w_pre_cnt = w_pre_cnt + (PW+1)'(w_pre[i]);
  end
`else
  assign w_pre     = '0;
  assign w_pre_cnt = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and per-cycle grant decision
  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = 1'b0;
    w_enter_arb  = 1'b0;
    w_scan_grant = 1'b0;
    w_scan_done  = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACTIVE: begin
        if (frame_start) begin
          w_state_nxt = ST_ARB;
          w_enter_arb = 1'b1;
        end
      end
      ST_ARB: begin
        w_busy       = 1'b1;
        w_scan_grant = req[w_idx] && !r_grant[w_idx] && (r_cnt < MAX_W);
        if (r_scan == SCAN_LAST) begin
          w_scan_done = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant vector and round-robin pointer including this cycle's grant
  always_comb begin
    w_grant_nxt = r_grant;
    if (w_scan_grant) w_grant_nxt[w_idx] = 1'b1;
    w_last_nxt = w_scan_grant ? w_idx : r_last_idx;
    w_any_nxt  = r_any | w_scan_grant;
    w_rr_nxt   = (w_last_nxt == SCAN_LAST) ? '0 : w_last_nxt + PW'(1);
  end

  // Arbitration datapath: partial grants, origin latches, frame grant, pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan     <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_any      <= 1'b0;
      r_last_idx <= '0;
      r_rr_ptr   <= '0;
      r_chosen   <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
    end else if (w_enter_arb) begin
      r_scan     <= '0;
      r_grant    <= w_pre;
      r_cnt      <= w_pre_cnt;
      r_any      <= 1'b0;
      r_last_idx <= '0;
      for (int i = 0; i < NSPR; i++) begin
        if (w_pre[i]) begin
          r_x0[i*10 +: 10] <= req_x0[i*10 +: 10];
          r_y0[i*9 +: 9]   <= req_y0[i*9 +: 9];
        end
      end
    end else if (w_busy) begin
      r_scan     <= r_scan + PW'(1);
      r_grant    <= w_grant_nxt;
      r_any      <= w_any_nxt;
      r_last_idx <= w_last_nxt;
      if (w_scan_grant) begin
        r_cnt                <= r_cnt + (PW+1)'(1);
        r_x0[w_idx*10 +: 10] <= req_x0[w_idx*10 +: 10];
        r_y0[w_idx*9 +: 9]   <= req_y0[w_idx*9 +: 9];
      end
      if (w_scan_done) begin
        r_chosen <= w_grant_nxt;
        if (w_any_nxt) r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  for (genvar gi = 0; gi < NSPR; gi++) begin : g_hit
    sprite_box_hit #(.SCALE(SCALE)) u_hit (
      .i_x  (r_x_d),
      .i_y  (r_y_d),
      .i_x0 (r_x0[gi*10 +: 10]),
      .i_y0 (r_y0[gi*9 +: 9]),
      .o_hit(w_hit[gi])
    );
  end

  // Lowest-index visible, non-white sprite wins; otherwise background
  always_comb begin
    w_pix = BG_WHITE;
    for (int i = NSPR-1; i >= 0; i--) begin
      if (r_chosen[i] && w_hit[i] && (spr_rgb[i*24 +: 24] != BG_WHITE))
        w_pix = spr_rgb[i*24 +: 24];
    end
  end

  // Pixel pipeline: delay x,y to meet spr_rgb, then register the composite
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_d <= '0;
      r_y_d <= '0;
      r_pix <= BG_WHITE;
    end else begin
      r_x_d <= x;
      r_y_d <= y;
      r_pix <= w_pix;
    end
  end

  assign chosen = r_chosen;
  assign x0_out = r_x0;
  assign y0_out = r_y0;
  assign busy   = w_busy;
  assign r      = r_pix[23:16];
  assign g      = r_pix[15:8];
  assign b      = r_pix[7:0];

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: directed cases plus random
// frames and pixels compared to a behavioural arbitration/compositing model.
module tb_sprite_scheduler;

  localparam int NSPR = 4, MAX_ACT = 2, SCALE = 8, BOX = 16 * SCALE;

  logic                clk = 1'b0, rst = 1'b0, frame_start = 1'b0;
  logic [9:0]          x = '0;
  logic [8:0]          y = '0;
  logic [NSPR-1:0]     req = '0, chosen;
  logic [NSPR*10-1:0]  req_x0 = '0, x0_out;
  logic [NSPR*9-1:0]   req_y0 = '0, y0_out;
  logic [NSPR*24-1:0]  spr_rgb = '0;
  logic [7:0]          r, g, b;
  logic                busy;

  sprite_scheduler #(.NSPR(NSPR), .MAX_ACT(MAX_ACT), .SCALE(SCALE)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start),
    .req(req), .req_x0(req_x0), .req_y0(req_y0), .spr_rgb(spr_rgb),
    .chosen(chosen), .x0_out(x0_out), .y0_out(y0_out),
    .r(r), .g(g), .b(b), .busy(busy)
  );

  always #5 clk = ~clk;

  int              n_vec = 0, n_err = 0;
  logic [NSPR-1:0] m_chosen;
  int              m_rr;
  int              m_x0 [NSPR];
  int              m_y0 [NSPR];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_chosen = '0;
    m_rr     = 0;
    for (int i = 0; i < NSPR; i++) begin
      m_x0[i] = 0;
      m_y0[i] = 0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #3;
    model_reset();
    rst = 1'b1;
    tick();
  endtask

  task automatic set_origin(input int i, input int ox, input int oy);
    req_x0[i*10 +: 10] = 10'(ox);
    req_y0[i*9 +: 9]   = 9'(oy);
  endtask

  // Who gets the frame: held sprites (if enabled), then up to MAX_ACT in
  // circular order from the pointer; pointer moves past the last new grant.
  task automatic model_arb();
    logic [NSPR-1:0] gr;
    int cnt, last, i;
    gr = '0; cnt = 0; last = -1;
`ifdef SPRITE_SCHED_HOLD_EN
    for (int k = 0; k < NSPR; k++) begin
      if (m_chosen[k] && req[k]) begin
        gr[k] = 1'b1; cnt++;
        m_x0[k] = int'(req_x0[k*10 +: 10]);
        m_y0[k] = int'(req_y0[k*9 +: 9]);
      end
    end
`endif
    for (int k = 0; k < NSPR; k++) begin
      i = (m_rr + k) % NSPR;
      if (req[i] && !gr[i] && cnt < MAX_ACT) begin
        gr[i] = 1'b1; cnt++; last = i;
        m_x0[i] = int'(req_x0[i*10 +: 10]);
        m_y0[i] = int'(req_y0[i*9 +: 9]);
      end
    end
    if (last >= 0) m_rr = (last + 1) % NSPR;
    m_chosen = gr;
  endtask

  task automatic run_frame(input string tag, input bit glitch);
    int n;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      frame_start = glitch && (n == 1);
      n++;
      tick();
    end
    frame_start = 1'b0;
    check_val({tag, "_busy_cycles"}, 64'(n), 64'(NSPR));
    model_arb();
    check_val({tag, "_chosen"}, 64'(chosen), 64'(m_chosen));
    for (int i = 0; i < NSPR; i++) begin
      check_val({tag, "_x0"}, 64'(x0_out[i*10 +: 10]), 64'(m_x0[i]));
      check_val({tag, "_y0"}, 64'(y0_out[i*9 +: 9]),   64'(m_y0[i]));
    end
  endtask

  task automatic pixel(input string tag, input int px, input int py,
                       input logic [NSPR*24-1:0] rgb, output logic [23:0] got);
    logic [23:0] exp, c;
    x = 10'(px);
    y = 9'(py);
    tick();
    spr_rgb = rgb;
    tick();
    exp = 24'hFFFFFF;
    for (int i = NSPR-1; i >= 0; i--) begin
      c = rgb[i*24 +: 24];
      if (m_chosen[i] && px > m_x0[i] && px <= m_x0[i] + BOX &&
          py > m_y0[i] && py <= m_y0[i] + BOX && c != 24'hFFFFFF)
        exp = c;
    end
    got = {r, g, b};
    check_val(tag, 64'(got), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0]        pix;
    logic [NSPR*24-1:0] rgbv;
    logic [23:0]        c;
    int                 k, px, py;

    model_reset();
    tick(); tick();
    check_val("rst_chosen", 64'(chosen), 64'(0));
    check_val("rst_busy",   64'(busy),   64'(0));
    check_val("rst_rgb",    64'({r, g, b}), 64'(24'hFFFFFF));
    check_val("rst_x0",     64'(x0_out), 64'(0));
    check_val("rst_y0",     64'(y0_out), 64'(0));
    rst = 1'b1;
    tick();

    // All four requesting for three frames
    req = 4'b1111;
    for (int i = 0; i < NSPR; i++) set_origin(i, 10 * i + 3, 7 * i + 2);
    run_frame("rr1", 1'b0);
    check_val("rr1_const", 64'(chosen), 64'(4'b0011));
    run_frame("rr2", 1'b0);
`ifdef SPRITE_SCHED_HOLD_EN
    check_val("rr2_const", 64'(chosen), 64'(4'b0011));
`else
    check_val("rr2_const", 64'(chosen), 64'(4'b1100));
`endif
    run_frame("rr3", 1'b0);
    check_val("rr3_const", 64'(chosen), 64'(4'b0011));

    // Single requester with a known origin
    apply_reset();
    req = 4'b0100;
    set_origin(2, 100, 50);
    run_frame("single", 1'b0);
    check_val("single_chosen", 64'(chosen), 64'(4'b0100));
    check_val("single_x0", 64'(x0_out[20 +: 10]), 64'(100));
    check_val("single_y0", 64'(y0_out[18 +: 9]),  64'(50));

    // Overlap priority and transparency
    apply_reset();
    req = 4'b0011;
    set_origin(0, 100, 50);
    set_origin(1, 110, 60);
    run_frame("ovl", 1'b0);
    rgbv = {24'h123456, 24'h654321, 24'h0F990F, 24'h0F0F0F};
    pixel("ovl_pix0", 120, 70, rgbv, pix);
    check_val("ovl_pix0_const", 64'(pix), 64'(24'h0F0F0F));
    rgbv[23:0] = 24'hFFFFFF;
    pixel("ovl_pix1", 120, 70, rgbv, pix);
    check_val("ovl_pix1_const", 64'(pix), 64'(24'h0F990F));
    pixel("outside", 5, 5, rgbv, pix);
    check_val("outside_const", 64'(pix), 64'(24'hFFFFFF));
    pixel("edge_x0", 100, 70, rgbv, pix);
    pixel("edge_x1", 238, 70, rgbv, pix);

    // Reset in the middle of arbitration
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_val("midarb_chosen", 64'(chosen), 64'(0));
    check_val("midarb_busy",   64'(busy),   64'(0));
    model_reset();
    #2;
    rst = 1'b1;
    tick(); tick();
    check_val("post_rst_chosen", 64'(chosen), 64'(0));
    run_frame("post_rst", 1'b0);

`ifdef SPRITE_SCHED_HOLD_EN
    apply_reset();
    req = 4'b1111;
    for (int f = 0; f < 3; f++) begin
      run_frame("hold", 1'b0);
      check_val("hold_const", 64'(chosen), 64'(4'b0011));
    end
    req = 4'b1110;
    run_frame("hold_drop", 1'b0);
    check_val("hold_drop_const", 64'(chosen), 64'(4'b0110));
`endif

    // Random frames, ignored frame_start glitches, ignored req changes
    for (int f = 0; f < 40; f++) begin
      req = NSPR'($urandom());
      for (int i = 0; i < NSPR; i++)
        set_origin(i, int'($urandom_range(0, 900)), int'($urandom_range(0, 400)));
      run_frame("rnd", ($urandom_range(0, 3) == 0));
      req = NSPR'($urandom());
      for (int p = 0; p < 6; p++) begin
        k  = int'($urandom_range(0, NSPR-1));
        px = m_x0[k] + int'($urandom_range(0, BOX + 2));
        py = m_y0[k] + int'($urandom_range(0, BOX + 2));
        if (px > 1023) px = 1023;
        if (py > 511)  py = 511;
        for (int i = 0; i < NSPR; i++) begin
          c = 24'($urandom());
          if ($urandom_range(0, 3) == 0) c = 24'hFFFFFF;
          rgbv[i*24 +: 24] = c;
        end
        pixel("rnd_pix", px, py, rgbv, pix);
      end
      check_val("rnd_hold_chosen", 64'(chosen), 64'(m_chosen));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 Parameter NSPR, default 4: number of sprite renderers served.
REQ-002 Parameter MAX_ACT, default 2: maximum sprites granted per frame, 1..NSPR.
REQ-003 Parameter SCALE, default 8: sprite pixel scale; sprite box is 16*SCALE square.
REQ-004 Port clk  in  1  pixel clock, rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port x  in  10  current pixel column; y  in  9  current pixel row.
REQ-007 Port frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-008 Port req  in  NSPR  per-sprite display request, level.
REQ-009 Port req_x0  in  NSPR*10, req_y0  in  NSPR*9: packed requested origins, sprite i at slice i.
REQ-010 Port spr_rgb  in  NSPR*24: packed {r,g,b} from renderers, valid one cycle after x,y.
REQ-011 Port chosen  out  NSPR: per-renderer enable.
REQ-012 Port x0_out  out  NSPR*10, y0_out  out  NSPR*9: latched origins driven to renderers.
REQ-013 Port r, g, b  out  8 each: composited pixel.
REQ-014 Port busy  out  1: high while arbitration in progress.

Function
REQ-015 States IDLE, ARB, ACTIVE; IDLE->ARB on frame_start; ARB->ACTIVE after NSPR scan cycles; ACTIVE->ARB on frame_start.
REQ-016 ARB scans one index per cycle starting at rr_ptr, wrapping modulo NSPR; index granted if req high at scan cycle and grant count < MAX_ACT.
REQ-017 On grant, req_x0/req_y0 slice latched into x0_out/y0_out slice in the same cycle.
REQ-018 chosen updates only on ARB->ACTIVE transition; stays constant for the whole frame.
REQ-019 On leaving ARB, rr_ptr = (last granted index + 1) mod NSPR; unchanged if no grant.
REQ-020 frame_start during ARB ignored; req changes during ACTIVE ignored until next ARB.
REQ-021 Box hit for sprite i: x0<x<=x0+16*SCALE and y0<y<=y0+16*SCALE, widths extended by 1 bit to avoid wrap.
REQ-022 Hit vector and x,y registered one cycle to align with spr_rgb.
REQ-023 Output pixel = spr_rgb of lowest-index sprite with chosen=1, delayed hit=1 and rgb != 24'hFFFFFF; else 24'hFFFFFF.
REQ-024 r,g,b registered: total latency x,y -> r,g,b = 2 cycles.
REQ-025 busy high exactly in ARB cycles.

Reset
REQ-026 On rst low: state IDLE, chosen 0, x0_out/y0_out 0, rr_ptr 0, r/g/b 8'hFF, busy 0, delay regs 0.
REQ-027 Reset mid-ARB or mid-frame discards partial grants; no grant visible until next ARB completes.

Configuration
REQ-028 Macro SPRITE_SCHED_HOLD_EN: when defined, sprite granted last frame with req still high is pre-granted at ARB start (counts toward MAX_ACT, origin relatched), remaining slots by round-robin.
REQ-029 Without SPRITE_SCHED_HOLD_EN, every ARB grants purely round-robin from rr_ptr.

Structure
REQ-030 Shared package sprite_pkg: state enum, BG_WHITE 24'hFFFFFF, SPR_CELLS=16.
REQ-031 Sub-module sprite_box_hit: one-instance-per-sprite box compare, combinational.

Verification
REQ-032 NSPR=4, MAX_ACT=2, req=4'b1111, three frame_starts -> chosen 0011, 1100, 0011.
REQ-033 req=4'b0100, req_x0[2]=100, req_y0[2]=50, frame_start -> after 4 busy cycles chosen=0100, x0_out[2]=100, y0_out[2]=50.
REQ-034 Sprites 0,1 granted, overlap at (120,70), spr_rgb0=0F0F0F, spr_rgb1=0F990F -> r,g,b=0F,0F,0F two cycles later; spr_rgb0=FFFFFF -> 0F,99,0F.
REQ-035 Pixel outside all boxes -> r,g,b=FF,FF,FF; rst low mid-ARB -> chosen=0, busy=0 immediately.
REQ-036 SPRITE_SCHED_HOLD_EN defined, req=1111 held -> chosen stays 0011 across frames; drop req[0] -> next frame chosen 0110.
